// File: rtl/apb_master_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_pkg
// Description : Shared types and constants for the APB command-stream master.
// Revision    : 1.0
// ============================================================================
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam int c_ADDR_W_DEFAULT  = 32;
    localparam int c_DATA_W_DEFAULT  = 32;
    localparam int c_TIMEOUT_DEFAULT = 16;

    // Register offsets of the ALU control slaves
    localparam logic [31:0] c_REG_TEST      = 32'h0000_0000;
    localparam logic [31:0] c_REG_LOGIC_SEL = 32'h0000_0004;
    localparam logic [31:0] c_REG_FINISH    = 32'h0000_0008;

endpackage
`default_nettype wire

// File: rtl/apb_master_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_ctrl_if
// Description : Command, response and APB bus signals of the APB master.
// Revision    : 1.0
// ============================================================================
interface apb_master_ctrl_if
    import apb_master_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEFAULT,
    parameter int DATA_W = c_DATA_W_DEFAULT
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_ctrl_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : apb_wait_timer
// Description : Saturating ACCESS wait counter with timeout-expired flag.
// Revision    : 1.0
// ============================================================================
module apb_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            clear,
    input  wire logic            en,
    output logic [TO_W-1:0]      count,
    output logic                 expired
);
    logic [TO_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (en && (r_count != {TO_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            // Flags the last permitted wait cycle so the abort lands on cycle TIMEOUT
            localparam logic [TO_W-1:0] c_LIMIT = TO_W'(TIMEOUT - 1);
            assign expired = (r_count == c_LIMIT);
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/apb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_ctrl
// Description : Valid/ready command stream to APB3 initiator, one outstanding.
// Revision    : 1.0
// ============================================================================
module apb_master_ctrl
    import apb_master_pkg::*;
#(
    parameter int ADDR_W  = c_ADDR_W_DEFAULT,
    parameter int DATA_W  = c_DATA_W_DEFAULT,
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT,
    parameter int TO_W    = 5
) (
    input  wire logic         clk,
    input  wire logic         rst,
    apb_master_ctrl_if.master bus
);
    apb_state_t        r_state,       w_state_nxt;
    logic              r_psel,        w_psel_nxt;
    logic              r_penable,     w_penable_nxt;
    logic              r_pwrite,      w_pwrite_nxt;
    logic [ADDR_W-1:0] r_paddr,       w_paddr_nxt;
    logic [DATA_W-1:0] r_pwdata,      w_pwdata_nxt;
    logic              r_rsp_valid,   w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata,   w_rsp_rdata_nxt;
    logic              r_rsp_err,     w_rsp_err_nxt;
    logic              w_tmr_clr;
    logic              w_tmr_en;
    logic              w_tmr_expired;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_tmr_clr),
        .en      (w_tmr_en),
        .count   (),
        .expired (w_tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_tmr_clr       = 1'b0;
        w_tmr_en        = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    w_pwrite_nxt  = bus.cmd_write;
                    w_paddr_nxt   = bus.cmd_addr;
                    w_pwdata_nxt  = bus.cmd_wdata;
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b0;
                    w_state_nxt   = SETUP;
                end
            end
            SETUP: begin
                w_penable_nxt = 1'b1;
                w_tmr_clr     = 1'b1;
                w_state_nxt   = ACCESS;
            end
            ACCESS: begin
                // A ready slave takes priority over a timeout on the same cycle
                if (bus.pready) begin
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_rdata_nxt = r_pwrite ? '0 : bus.prdata;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = RESP;
                end else if (w_tmr_expired) begin
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = RESP;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
endmodule
`default_nettype wire

// File: tb/tb_apb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_ctrl
// Description : Directed self-checking bench for apb_master_ctrl.
// Revision    : 1.0
// ============================================================================
module tb_apb_master_ctrl;
    import apb_master_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    apb_master_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16),
        .TO_W    (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = data;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;
        bus.prdata    = '0;
        bus.pready    = 1'b1;
        tick();
        tick();
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_psel", bus.psel, 0);
        check("rst_penable", bus.penable, 0);
        check("rst_pwrite", bus.pwrite, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_paddr", bus.paddr, 0);
        check("rst_pwdata", bus.pwdata, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        rst = 1'b0;
        tick();

        // Zero-wait write to LOGIC_SEL
        send_cmd(1'b1, c_REG_LOGIC_SEL, 32'h2);
        check("wr_setup_psel", bus.psel, 1);
        check("wr_setup_penable", bus.penable, 0);
        check("wr_setup_pwrite", bus.pwrite, 1);
        check("wr_setup_paddr", bus.paddr, 32'h4);
        check("wr_setup_pwdata", bus.pwdata, 32'h2);
        check("wr_setup_cmd_ready", bus.cmd_ready, 0);
        tick();
        check("wr_access_psel", bus.psel, 1);
        check("wr_access_penable", bus.penable, 1);
        check("wr_access_rsp_valid", bus.rsp_valid, 0);
        tick();
        check("wr_rsp_valid", bus.rsp_valid, 1);
        check("wr_rsp_err", bus.rsp_err, 0);
        check("wr_rsp_rdata", bus.rsp_rdata, 0);
        check("wr_rsp_psel", bus.psel, 0);
        tick();
        check("wr_done_rsp_valid", bus.rsp_valid, 0);
        check("wr_done_cmd_ready", bus.cmd_ready, 1);
        check("wr_done_paddr_held", bus.paddr, 32'h4);
        check("wr_done_pwdata_held", bus.pwdata, 32'h2);

        // Read with three wait cycles
        bus.pready = 1'b0;
        send_cmd(1'b0, c_REG_LOGIC_SEL, 32'h0);
        check("rd_setup_pwrite", bus.pwrite, 0);
        tick();
        check("rd_access1_penable", bus.penable, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rd_wait_penable", bus.penable, 1);
            check("rd_wait_rsp_valid", bus.rsp_valid, 0);
        end
        bus.pready = 1'b1;
        bus.prdata = 32'h2;
        tick();
        check("rd_rsp_valid", bus.rsp_valid, 1);
        check("rd_rsp_rdata", bus.rsp_rdata, 32'h2);
        check("rd_rsp_err", bus.rsp_err, 0);
        check("rd_rsp_penable", bus.penable, 0);
        tick();
        check("rd_done_rsp_valid", bus.rsp_valid, 0);

        // Timeout after 16 ACCESS cycles
        bus.pready = 1'b0;
        bus.prdata = 32'hDEAD_BEEF;
        send_cmd(1'b0, c_REG_FINISH, 32'h0);
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        check("to_cycle16_psel", bus.psel, 1);
        check("to_cycle16_penable", bus.penable, 1);
        check("to_cycle16_rsp_valid", bus.rsp_valid, 0);
        tick();
        check("to_abort_psel", bus.psel, 0);
        check("to_abort_penable", bus.penable, 0);
        check("to_abort_rsp_valid", bus.rsp_valid, 1);
        check("to_abort_rsp_err", bus.rsp_err, 1);
        check("to_abort_rsp_rdata", bus.rsp_rdata, 0);
        tick();
        check("to_done_cmd_ready", bus.cmd_ready, 1);
        bus.pready = 1'b1;
        bus.prdata = 32'h55;
        send_cmd(1'b0, c_REG_LOGIC_SEL, 32'h0);
        tick();
        tick();
        check("to_next_rsp_valid", bus.rsp_valid, 1);
        check("to_next_rsp_err", bus.rsp_err, 0);
        check("to_next_rsp_rdata", bus.rsp_rdata, 32'h55);
        tick();

        // Response backpressure with a queued command
        bus.rsp_ready = 1'b0;
        send_cmd(1'b1, c_REG_TEST, 32'h1);
        tick();
        tick();
        check("bp_rsp_valid", bus.rsp_valid, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = c_REG_FINISH;
        bus.cmd_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_rsp_valid", bus.rsp_valid, 1);
            check("bp_hold_rsp_rdata", bus.rsp_rdata, 0);
            check("bp_hold_rsp_err", bus.rsp_err, 0);
            check("bp_hold_cmd_ready", bus.cmd_ready, 0);
            check("bp_hold_psel", bus.psel, 0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("bp_release_rsp_valid", bus.rsp_valid, 0);
        check("bp_release_cmd_ready", bus.cmd_ready, 1);
        check("bp_release_psel", bus.psel, 0);
        tick();
        bus.cmd_valid = 1'b0;
        check("bp_accept_psel", bus.psel, 1);
        check("bp_accept_paddr", bus.paddr, 32'h8);
        check("bp_accept_pwrite", bus.pwrite, 0);
        tick();
        tick();
        check("bp_next_rsp_valid", bus.rsp_valid, 1);
        tick();

        // Reset while in ACCESS
        bus.pready = 1'b0;
        send_cmd(1'b1, c_REG_LOGIC_SEL, 32'h3);
        tick();
        check("rst_mid_penable", bus.penable, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_psel", bus.psel, 0);
        check("rst_mid_penable_low", bus.penable, 0);
        check("rst_mid_rsp_valid", bus.rsp_valid, 0);
        check("rst_mid_cmd_ready", bus.cmd_ready, 1);
        bus.pready = 1'b1;
        send_cmd(1'b1, c_REG_TEST, 32'h7);
        check("rst_next_psel", bus.psel, 1);
        check("rst_next_paddr", bus.paddr, 32'h0);
        check("rst_next_pwdata", bus.pwdata, 32'h7);
        tick();
        tick();
        check("rst_next_rsp_valid", bus.rsp_valid, 1);
        check("rst_next_rsp_err", bus.rsp_err, 0);
        tick();

        // pready arrives on the 16th ACCESS cycle: success beats timeout
        bus.pready = 1'b0;
        bus.prdata = 32'hA5A5;
        send_cmd(1'b0, c_REG_LOGIC_SEL, 32'h0);
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        check("tie_cycle16_penable", bus.penable, 1);
        bus.pready = 1'b1;
        tick();
        check("tie_rsp_valid", bus.rsp_valid, 1);
        check("tie_rsp_err", bus.rsp_err, 0);
        check("tie_rsp_rdata", bus.rsp_rdata, 32'hA5A5);
        tick();
        check("tie_done_cmd_ready", bus.cmd_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
